// File: rtl/grant_burst_ctrl.sv
// Burst controller behind a 4-requester arbiter: locks a one-hot grant and
// streams BURST_LEN beats of that requester's data, then pulses done_o.
module grant_burst_ctrl #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          gnt_i,
  input  logic [4*DATA_W-1:0] data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [DATA_W-1:0]   out_data_o,
  output logic [1:0]          out_id_o,
  output logic                busy_o,
  output logic [3:0]          done_o,
  output logic                err_o
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        id_q, id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      id_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_i != '0) begin
          // x & (x-1) is non-zero exactly when more than one bit is set
          if ((gnt_i & (gnt_i - 4'd1)) != '0) begin
            err_d = 1'b1;
          end else begin
            id_d    = {gnt_i[3] | gnt_i[2], gnt_i[3] | gnt_i[1]};
            cnt_d   = '0;
            state_d = XFER;
          end
        end
      end
      XFER: begin
        if (out_ready_i) begin
          if (cnt_q == LAST_BEAT) state_d = DONE;
          else                    cnt_d   = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid_o = (state_q == XFER);
    busy_o      = (state_q != IDLE);
    out_id_o    = id_q;
    err_o       = err_q;
    done_o      = (state_q == DONE) ? (4'b0001 << id_q) : 4'b0000;
    out_data_o  = (state_q == XFER) ? data_i[32'(id_q) * DATA_W +: DATA_W] : '0;
  end

endmodule

// File: tb/tb_grant_burst_ctrl.sv
// Bench for grant_burst_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a beats-remaining reference model.
module tb_grant_burst_ctrl;

  localparam int DW = 8;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    gnt;
  logic [4*DW-1:0] data_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    out_id;
  logic          busy;
  logic [3:0]    done;
  logic          err;

  grant_burst_ctrl #(.DATA_W(DW), .BURST_LEN(BL)) dut (
    .clk        (clk),
    .reset      (reset),
    .gnt_i      (gnt),
    .data_i     (data_in),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_id_o   (out_id),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: beats still owed, pending completion, locked id, error pulse
  int m_left = 0;
  bit m_done = 1'b0;
  int m_id   = 0;
  bit m_err  = 1'b0;

  int beats = 0;
  int dones = 0;
  int errs  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    int ones;
    ones = $countones(gnt);
    if (reset) begin
      m_left = 0; m_done = 1'b0; m_id = 0; m_err = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0; m_err = 1'b0;
    end else if (m_left > 0) begin
      m_err = 1'b0;
      if (out_ready) begin
        m_left--;
        if (m_left == 0) m_done = 1'b1;
      end
    end else begin
      m_err = (ones > 1);
      if (ones == 1) begin
        for (int i = 0; i < 4; i++) if (gnt[i]) m_id = i;
        m_left = BL;
      end
    end
  endtask

  task automatic cycle();
    logic [DW-1:0] exp_data;
    @(negedge clk);
    exp_data = (m_left > 0) ? data_in[m_id*DW +: DW] : '0;
    chk("valid", {31'd0, out_valid}, {31'd0, m_left > 0});
    chk("busy",  {31'd0, busy},      {31'd0, (m_left > 0) || m_done});
    chk("id",    {30'd0, out_id},    32'(m_id));
    chk("data",  {24'd0, out_data},  {24'd0, exp_data});
    chk("done",  {28'd0, done},      m_done ? (32'd1 << m_id) : 32'd0);
    chk("err",   {31'd0, err},       {31'd0, m_err});
    if (out_valid && out_ready) beats++;
    if (done != 4'b0000) dones++;
    if (err) errs++;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clr_counts();
    beats = 0; dones = 0; errs = 0;
  endtask

  initial begin
    bit [5:0] bp_pat;
    int r;

    // Reset held with a pending grant
    reset = 1'b1; gnt = 4'b0100; out_ready = 1'b1; data_in = $urandom;
    @(posedge clk); model_step(); #1;
    cycle();
    cycle();
    reset = 1'b0; gnt = 4'b0000;
    clr_counts();
    repeat (3) cycle();
    chk("idle_after_reset_beats", beats, 0);

    // Single burst from requester 3
    data_in = $urandom; data_in[31:24] = 8'hA5;
    gnt = 4'b1000;
    cycle();
    gnt = 4'b0000;
    clr_counts();
    repeat (7) cycle();
    chk("single_beats", beats, BL);
    chk("single_dones", dones, 1);

    // Backpressure on requester 1
    gnt = 4'b0010; data_in = $urandom;
    cycle();
    gnt = 4'b0000;
    clr_counts();
    bp_pat = 6'b111001;  // applied LSB first: 1,0,0,1,1,1
    for (int i = 0; i < 6; i++) begin
      out_ready = bp_pat[i];
      cycle();
    end
    out_ready = 1'b1;
    repeat (3) cycle();
    chk("bp_beats", beats, BL);
    chk("bp_dones", dones, 1);

    // Illegal multi-bit grant
    clr_counts();
    gnt = 4'b1010;
    cycle();
    gnt = 4'b0000;
    repeat (3) cycle();
    chk("illegal_errs",  errs, 1);
    chk("illegal_beats", beats, 0);

    // Grant change mid-burst is ignored; held grant starts the next burst
    clr_counts();
    gnt = 4'b0010;
    cycle();
    gnt = 4'b0100;
    repeat (14) cycle();
    gnt = 4'b0000;
    repeat (4) cycle();
    chk("b2b_dones", dones, 3);

    // Reset after two accepted beats
    clr_counts();
    gnt = 4'b0001;
    cycle();
    gnt = 4'b0000;
    repeat (2) cycle();
    chk("rst_mid_beats", beats, 2);
    out_ready = 1'b0; reset = 1'b1;
    cycle();
    reset = 1'b0; out_ready = 1'b1;
    cycle();
    clr_counts();
    gnt = 4'b0100;
    cycle();
    gnt = 4'b0000;
    repeat (6) cycle();
    chk("rst_mid_fresh_beats", beats, BL);
    chk("rst_mid_fresh_dones", dones, 1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(99);
      if (r < 50)      gnt = 4'b0000;
      else if (r < 85) gnt = 4'b0001 << $urandom_range(3);
      else             gnt = 4'($urandom);
      out_ready = ($urandom_range(3) != 0);
      reset     = ($urandom_range(99) < 2);
      data_in   = $urandom;
      cycle();
    end
    reset = 1'b0; gnt = 4'b0000; out_ready = 1'b1;
    repeat (BL + 3) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
